// File: rtl/dmac_write_handler.sv
// DMA write-side mover: queues burst lengths, streams AXI W beats with WLAST,
// tracks outstanding bursts against B responses and reports errors.
module dmac_write_handler #(
    parameter int DATA_WD         = 32,
    parameter int MAX_BURST_LEN   = 16,
    parameter int CMD_FIFO_DEPTH  = 4,
    parameter int MAX_OUTSTANDING = 8,
    localparam int STRB_WD        = DATA_WD / 8,
    localparam int LEN_WD         = $clog2(MAX_BURST_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               burst_cmd_valid,
    output logic               burst_cmd_ready,
    input  logic [LEN_WD-1:0]  burst_cmd_len,
    input  logic               data_in_valid,
    output logic               data_in_ready,
    input  logic [DATA_WD-1:0] data_in,
    output logic               m_axi_wvalid,
    input  logic               m_axi_wready,
    output logic [DATA_WD-1:0] m_axi_wdata,
    output logic [STRB_WD-1:0] m_axi_wstrb,
    output logic               m_axi_wlast,
    input  logic               m_axi_bvalid,
    output logic               m_axi_bready,
    input  logic [1:0]         m_axi_bresp,
    output logic               wr_resp_valid,
    output logic               wr_resp_err,
    output logic               err_sticky,
    input  logic               err_clear,
    output logic               idle
);

    localparam int AW = $clog2(CMD_FIFO_DEPTH);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_DATA = 1'b1;

    logic [LEN_WD-1:0] fifo_mem [CMD_FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       fifo_cnt;
    logic [AW:0]       fifo_cnt_nxt;
    logic              fifo_empty;
    logic              push;
    logic              pop;

    logic [0:0]        state;
    logic [0:0]        state_nxt;
    logic [LEN_WD-1:0] cur_len;
    logic [LEN_WD-1:0] beat_cnt;
    logic [OW-1:0]     outstanding;
    logic [OW-1:0]     outstanding_nxt;

    logic              in_data;
    logic              w_hs;
    logic              b_hs;
    logic              is_last;
    logic              can_pop;
    logic              unused_bresp;

    assign unused_bresp    = m_axi_bresp[0];

    assign fifo_empty      = (fifo_cnt == '0);
    assign burst_cmd_ready = (fifo_cnt != (AW+1)'(CMD_FIFO_DEPTH));
    assign push            = burst_cmd_valid && burst_cmd_ready;
    assign can_pop         = !fifo_empty &&
                             (outstanding < OW'(MAX_OUTSTANDING));

    assign in_data       = (state == S_DATA);
    assign is_last       = (beat_cnt == cur_len);
    assign m_axi_wvalid  = in_data && data_in_valid;
    assign data_in_ready = in_data && m_axi_wready;
    assign m_axi_wdata   = data_in;
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = in_data && is_last;
    assign w_hs          = in_data && data_in_valid && m_axi_wready;

    assign m_axi_bready  = (outstanding != '0);
    assign b_hs          = m_axi_bvalid && m_axi_bready;

    always_comb begin
        pop       = 1'b0;
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (can_pop) begin
                    pop       = 1'b1;
                    state_nxt = S_DATA;
                end
            end
            default: begin
                // Chain the next burst on the last beat so W never bubbles.
                if (w_hs && is_last) begin
                    if (can_pop) pop = 1'b1;
                    else         state_nxt = S_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        outstanding_nxt = outstanding;
        case ({pop, b_hs})
            2'b10:   outstanding_nxt = outstanding + 1'b1;
            2'b01:   outstanding_nxt = outstanding - 1'b1;
            default: outstanding_nxt = outstanding;
        endcase
    end

    always_comb begin
        fifo_cnt_nxt = fifo_cnt;
        case ({push, pop})
            2'b10:   fifo_cnt_nxt = fifo_cnt + 1'b1;
            2'b01:   fifo_cnt_nxt = fifo_cnt - 1'b1;
            default: fifo_cnt_nxt = fifo_cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= burst_cmd_len;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_cnt      <= '0;
            state         <= S_IDLE;
            cur_len       <= '0;
            beat_cnt      <= '0;
            outstanding   <= '0;
            wr_resp_valid <= 1'b0;
            wr_resp_err   <= 1'b0;
            err_sticky    <= 1'b0;
            idle          <= 1'b1;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            fifo_cnt    <= fifo_cnt_nxt;
            state       <= state_nxt;
            outstanding <= outstanding_nxt;

            if (pop) begin
                cur_len  <= fifo_mem[rd_ptr];
                beat_cnt <= '0;
            end else if (w_hs) begin
                beat_cnt <= beat_cnt + 1'b1;
            end

            wr_resp_valid <= b_hs;
            wr_resp_err   <= b_hs && m_axi_bresp[1];

            if (b_hs && m_axi_bresp[1]) err_sticky <= 1'b1;
            else if (err_clear)         err_sticky <= 1'b0;

            idle <= (fifo_cnt_nxt == '0) && (state_nxt == S_IDLE) &&
                    (outstanding_nxt == '0);
        end
    end

endmodule

// File: tb/tb_dmac_write_handler.sv
// Scoreboard bench for dmac_write_handler: directed bursts, backpressure,
// outstanding limit, error reporting and mid-burst reset.
module tb_dmac_write_handler;

    typedef struct {
        logic [31:0] d;
        logic        l;
    } wbeat_t;

    logic        clk;
    logic        rst;
    logic        burst_cmd_valid;
    logic        burst_cmd_ready;
    logic [3:0]  burst_cmd_len;
    logic        data_in_valid;
    logic        data_in_ready;
    logic [31:0] data_in;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wlast;
    logic        m_axi_bvalid;
    logic        m_axi_bready;
    logic [1:0]  m_axi_bresp;
    logic        wr_resp_valid;
    logic        wr_resp_err;
    logic        err_sticky;
    logic        err_clear;
    logic        idle;

    wbeat_t exp_w[$];
    logic   exp_r[$];
    int     hs_cyc[$];
    wbeat_t e;
    logic   er;
    int     total  = 0;
    int     passed = 0;
    int     cyc    = 0;
    int     beats  = 0;
    int     lasts  = 0;
    int     resps  = 0;
    bit     done;

    dmac_write_handler dut (
        .clk             (clk),
        .rst             (rst),
        .burst_cmd_valid (burst_cmd_valid),
        .burst_cmd_ready (burst_cmd_ready),
        .burst_cmd_len   (burst_cmd_len),
        .data_in_valid   (data_in_valid),
        .data_in_ready   (data_in_ready),
        .data_in         (data_in),
        .m_axi_wvalid    (m_axi_wvalid),
        .m_axi_wready    (m_axi_wready),
        .m_axi_wdata     (m_axi_wdata),
        .m_axi_wstrb     (m_axi_wstrb),
        .m_axi_wlast     (m_axi_wlast),
        .m_axi_bvalid    (m_axi_bvalid),
        .m_axi_bready    (m_axi_bready),
        .m_axi_bresp     (m_axi_bresp),
        .wr_resp_valid   (wr_resp_valid),
        .wr_resp_err     (wr_resp_err),
        .err_sticky      (err_sticky),
        .err_clear       (err_clear),
        .idle            (idle)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0b expected %0b", nm, act, exp);
    endtask

    task automatic fail(input string nm, input string msg);
        total++;
        $display("FAIL %s: %s", nm, msg);
    endtask

    // Monitor: every W handshake and response pulse is popped and compared.
    initial forever begin
        @(negedge clk);
        if (m_axi_wvalid && m_axi_wready) begin
            beats++;
            hs_cyc.push_back(cyc);
            if (m_axi_wlast) lasts++;
            if (exp_w.size() == 0) begin
                fail("w_unexpected", $sformatf("beat %0h", m_axi_wdata));
            end else begin
                e = exp_w.pop_front();
                chk("wdata", m_axi_wdata, e.d);
                chk1("wlast", m_axi_wlast, e.l);
                chk("wstrb", 32'(m_axi_wstrb), 32'hf);
            end
        end
        if (wr_resp_valid) begin
            resps++;
            if (exp_r.size() == 0) begin
                fail("resp_unexpected", "pulse with nothing expected");
            end else begin
                er = exp_r.pop_front();
                chk1("wr_resp_err", wr_resp_err, er);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [3:0] len);
        bit ok;
        ok = 0;
        burst_cmd_valid = 1'b1;
        burst_cmd_len   = len;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (burst_cmd_ready) ok = 1;
            tick();
        end
        burst_cmd_valid = 1'b0;
        if (!ok) fail("cmd_timeout", "burst_cmd_ready never rose");
    endtask

    task automatic send_beat(input logic [31:0] d);
        bit ok;
        ok = 0;
        data_in       = d;
        data_in_valid = 1'b1;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (data_in_ready) ok = 1;
            tick();
        end
        data_in_valid = 1'b0;
        if (!ok) fail("beat_timeout", $sformatf("beat %0h stuck", d));
    endtask

    task automatic send_b(input logic [1:0] r, input logic clr);
        bit ok;
        ok = 0;
        exp_r.push_back(r[1]);
        m_axi_bvalid = 1'b1;
        m_axi_bresp  = r;
        err_clear    = clr;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (m_axi_bready) ok = 1;
            tick();
        end
        m_axi_bvalid = 1'b0;
        m_axi_bresp  = 2'b00;
        err_clear    = 1'b0;
        if (!ok) fail("b_timeout", "bready never rose");
    endtask

    task automatic exp_beat(input logic [31:0] d, input logic l);
        wbeat_t b;
        b.d = d;
        b.l = l;
        exp_w.push_back(b);
    endtask

    task automatic drain();
        repeat (3) tick();
        chk("w_queue_left", exp_w.size(), 0);
        chk("r_queue_left", exp_r.size(), 0);
    endtask

    initial begin
        int b0;
        int l0;
        int r0;
        int nb;
        rst             = 1'b0;
        burst_cmd_valid = 1'b0;
        burst_cmd_len   = '0;
        data_in_valid   = 1'b0;
        data_in         = '0;
        m_axi_wready    = 1'b1;
        m_axi_bvalid    = 1'b0;
        m_axi_bresp     = 2'b00;
        err_clear       = 1'b0;
        done            = 0;

        repeat (3) tick();
        @(negedge clk);
        chk1("rst_cmd_ready", burst_cmd_ready, 1'b1);
        chk1("rst_idle", idle, 1'b1);
        chk1("rst_wvalid", m_axi_wvalid, 1'b0);
        chk1("rst_bready", m_axi_bready, 1'b0);
        chk1("rst_resp_valid", wr_resp_valid, 1'b0);
        chk1("rst_err_sticky", err_sticky, 1'b0);
        rst = 1'b1;
        tick();

        // Single burst of four beats
        b0 = beats; l0 = lasts; r0 = resps;
        for (int i = 0; i < 4; i++) exp_beat(32'hA0 + i, i == 3);
        push_cmd(4'd3);
        for (int i = 0; i < 4; i++) send_beat(32'hA0 + i);
        tick();
        send_b(2'b00, 1'b0);
        drain();
        chk("t1_beats", beats - b0, 4);
        chk("t1_lasts", lasts - l0, 1);
        chk("t1_resps", resps - r0, 1);
        @(negedge clk);
        chk1("t1_idle", idle, 1'b1);
        tick();

        // Back-to-back bursts, len 1 then len 2
        hs_cyc.delete();
        l0 = lasts;
        exp_beat(32'hB0, 1'b0);
        exp_beat(32'hB1, 1'b1);
        exp_beat(32'hB2, 1'b0);
        exp_beat(32'hB3, 1'b0);
        exp_beat(32'hB4, 1'b1);
        push_cmd(4'd1);
        push_cmd(4'd2);
        for (int i = 0; i < 5; i++) send_beat(32'hB0 + i);
        chk("t2_hs_count", hs_cyc.size(), 5);
        if (hs_cyc.size() == 5)
            chk("t2_span", hs_cyc[4] - hs_cyc[0], 4);
        chk("t2_lasts", lasts - l0, 2);
        @(negedge clk);
        chk1("t2_bready_two", m_axi_bready, 1'b1);
        tick();
        send_b(2'b00, 1'b0);
        @(negedge clk);
        chk1("t2_bready_one", m_axi_bready, 1'b1);
        tick();
        send_b(2'b00, 1'b0);
        @(negedge clk);
        chk1("t2_bready_zero", m_axi_bready, 1'b0);
        drain();

        // Backpressure on both W ready and the input stream
        b0 = beats; l0 = lasts;
        for (int i = 0; i < 8; i++) exp_beat(32'hC0 + i, i == 7);
        done = 0;
        fork
            begin
                push_cmd(4'd7);
                for (int i = 0; i < 8; i++) begin
                    repeat ($urandom_range(0, 2)) tick();
                    send_beat(32'hC0 + i);
                end
                done = 1;
            end
            begin
                while (!done) begin
                    tick();
                    m_axi_wready = 1'($urandom_range(0, 1));
                end
                m_axi_wready = 1'b1;
            end
        join
        chk("t3_beats", beats - b0, 8);
        chk("t3_lasts", lasts - l0, 1);
        send_b(2'b00, 1'b0);
        drain();

        // Outstanding limit: ten single-beat bursts, B held off
        for (int i = 0; i < 8; i++) exp_beat(32'hD0 + i, 1'b1);
        fork
            for (int i = 0; i < 10; i++) push_cmd(4'd0);
            for (int i = 0; i < 8; i++) send_beat(32'hD0 + i);
        join
        b0 = beats;
        data_in       = 32'hD8;
        data_in_valid = 1'b1;
        repeat (10) tick();
        chk("t4_stall_8", beats - b0, 0);
        exp_beat(32'hD8, 1'b1);
        send_b(2'b00, 1'b0);
        send_beat(32'hD8);
        chk("t4_released", beats - b0, 1);
        b0 = beats;
        data_in       = 32'hD9;
        data_in_valid = 1'b1;
        repeat (8) tick();
        chk("t4_stall_9", beats - b0, 0);
        exp_beat(32'hD9, 1'b1);
        send_b(2'b00, 1'b0);
        send_beat(32'hD9);
        nb = 0;
        for (int i = 0; i < 12 && m_axi_bready; i++) begin
            send_b(2'b00, 1'b0);
            nb++;
        end
        chk("t4_remaining_b", nb, 8);
        @(negedge clk);
        chk1("t4_bready_zero", m_axi_bready, 1'b0);
        drain();

        // Error reporting and sticky flag
        for (int i = 0; i < 3; i++) exp_beat(32'hE0 + i, 1'b1);
        for (int i = 0; i < 3; i++) push_cmd(4'd0);
        for (int i = 0; i < 3; i++) send_beat(32'hE0 + i);
        send_b(2'b00, 1'b0);
        @(negedge clk);
        chk1("t5_sticky_ok", err_sticky, 1'b0);
        tick();
        send_b(2'b10, 1'b0);
        @(negedge clk);
        chk1("t5_sticky_set", err_sticky, 1'b1);
        tick();
        send_b(2'b00, 1'b0);
        @(negedge clk);
        chk1("t5_sticky_hold", err_sticky, 1'b1);
        tick();
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        @(negedge clk);
        chk1("t5_sticky_clr", err_sticky, 1'b0);
        tick();
        exp_beat(32'hE3, 1'b1);
        push_cmd(4'd0);
        send_beat(32'hE3);
        send_b(2'b11, 1'b1);
        @(negedge clk);
        chk1("t5_set_wins", err_sticky, 1'b1);
        tick();
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        drain();
        @(negedge clk);
        chk1("t5_sticky_end", err_sticky, 1'b0);
        chk1("t5_idle", idle, 1'b1);
        tick();

        // Reset after two of four beats
        exp_beat(32'hF0, 1'b0);
        exp_beat(32'hF1, 1'b0);
        push_cmd(4'd3);
        send_beat(32'hF0);
        send_beat(32'hF1);
        rst = 1'b0;
        tick();
        data_in       = 32'hF2;
        data_in_valid = 1'b1;
        @(negedge clk);
        chk1("t6_wvalid", m_axi_wvalid, 1'b0);
        chk1("t6_din_ready", data_in_ready, 1'b0);
        chk1("t6_bready", m_axi_bready, 1'b0);
        chk1("t6_cmd_ready", burst_cmd_ready, 1'b1);
        chk1("t6_idle", idle, 1'b1);
        tick();
        data_in_valid = 1'b0;
        rst = 1'b1;
        drain();
        @(negedge clk);
        chk1("t6_idle_after", idle, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
